// File: rtl/uart_cmd_parser.sv
// UART command parser: pops bytes from an FWFT RX FIFO, decodes them against CMD_TABLE and fires
// one-hot command strobes, optionally after a decimal argument. Optional echo: define CMD_ECHO_EN.
module uart_cmd_parser #(
  parameter int unsigned          NUM_CMD     = 12,
  parameter logic [8*NUM_CMD-1:0] CMD_TABLE   = "@321srmcSMHL",
  parameter logic [NUM_CMD-1:0]   TOGGLE_MASK = 12'h0A1,
  parameter logic [NUM_CMD-1:0]   ARG_MASK    = 12'h00E,
  parameter int unsigned          ARG_DIGITS  = 2,
  parameter int unsigned          ARG_W       = 7,
  parameter int unsigned          TIMEOUT_CYC = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_empty,
  output logic               rx_pop,
  output logic [NUM_CMD-1:0] cmd_pulse,
  output logic [NUM_CMD-1:0] cmd_level,
  output logic [ARG_W-1:0]   arg_value,
  output logic               arg_valid,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         tx_data,
  output logic               tx_push,
  input  logic               tx_full
);
  localparam int unsigned        IDX_W      = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
  localparam int unsigned        TMR_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]         DIGITS_MAX = 3'(ARG_DIGITS);
  localparam logic [ARG_W+3:0]   ACC_SAT    = {4'b0, {ARG_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, POP, DECODE, ARG_WAIT, ARG_POP, ARG_CHK, FIRE} state_t;
  typedef enum logic [1:0] {ERR_UNKNOWN, ERR_DIGIT, ERR_EMPTY, ERR_TIMEOUT} err_t;

  state_t             state, state_n;
  logic [7:0]         byte_q, byte_n;
  logic [IDX_W-1:0]   idx_q, idx_n, fire_idx;
  logic [ARG_W-1:0]   acc_q, acc_n, acc_dig, fire_val;
  logic [ARG_W+3:0]   acc_mac;
  logic [2:0]         cnt_q, cnt_n, cnt_inc;
  logic [TMR_W-1:0]   tmr_q, tmr_n;
  logic               pop_n, fire, fire_arg, err_n;
  logic [1:0]         code_n;
  logic [NUM_CMD-1:0] pulse_n, level_n;
  logic               hit, is_term, is_digit;
  logic [IDX_W-1:0]   hit_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_CMD) - 1; i >= 0; i--) begin
      if (byte_q == CMD_TABLE[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign is_term  = (byte_q == 8'h0D) || (byte_q == 8'h0A);
  assign is_digit = (byte_q >= 8'h30) && (byte_q <= 8'h39);
  assign cnt_inc  = cnt_q + 3'd1;
  assign acc_mac  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{ARG_W{1'b0}}, byte_q[3:0]};
  assign acc_dig  = (acc_mac > ACC_SAT) ? {ARG_W{1'b1}} : acc_mac[ARG_W-1:0];

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_n  = state;
    byte_n   = byte_q;
    idx_n    = idx_q;
    acc_n    = acc_q;
    cnt_n    = cnt_q;
    tmr_n    = tmr_q;
    pop_n    = 1'b0;
    fire     = 1'b0;
    fire_arg = 1'b0;
    fire_idx = idx_q;
    fire_val = acc_q;
    err_n    = 1'b0;
    code_n   = err_code;
    unique case (state)
      IDLE: if (!rx_empty) begin
        byte_n  = rx_data;
        pop_n   = 1'b1;
        state_n = POP;
      end
      POP: state_n = DECODE;
      DECODE: begin
        state_n = IDLE;
        if (hit) begin
          idx_n = hit_idx;
          if (ARG_MASK[hit_idx]) begin
            acc_n   = '0;
            cnt_n   = '0;
            tmr_n   = '0;
            state_n = ARG_WAIT;
          end else begin
            fire     = 1'b1;
            fire_idx = hit_idx;
            state_n  = FIRE;
          end
        end else if (!is_term) begin
          err_n  = 1'b1;
          code_n = ERR_UNKNOWN;
        end
      end
      ARG_WAIT: begin
        if (!rx_empty) begin
          byte_n  = rx_data;
          pop_n   = 1'b1;
          state_n = ARG_POP;
        end else if (tmr_q == TMR_LAST) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      ARG_POP: state_n = ARG_CHK;
      ARG_CHK: begin
        state_n = IDLE;
        if (is_digit) begin
          acc_n = acc_dig;
          cnt_n = cnt_inc;
          if (cnt_inc == DIGITS_MAX) begin
            fire     = 1'b1;
            fire_arg = 1'b1;
            fire_val = acc_dig;
            state_n  = FIRE;
          end else begin
            tmr_n   = '0;
            state_n = ARG_WAIT;
          end
        end else if (is_term && (cnt_q != 3'd0)) begin
          fire     = 1'b1;
          fire_arg = 1'b1;
          state_n  = FIRE;
        end else begin
          err_n  = 1'b1;
          code_n = is_term ? ERR_EMPTY : ERR_DIGIT;
        end
      end
      FIRE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    pulse_n = fire ? (NUM_CMD'(1) << fire_idx) : '0;
    level_n = cmd_level ^ (pulse_n & TOGGLE_MASK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      byte_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      rx_pop    <= 1'b0;
      cmd_pulse <= '0;
      cmd_level <= '0;
      arg_value <= '0;
      arg_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state     <= state_n;
      byte_q    <= byte_n;
      idx_q     <= idx_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      tmr_q     <= tmr_n;
      rx_pop    <= pop_n;
      cmd_pulse <= pulse_n;
      cmd_level <= level_n;
      arg_valid <= fire_arg;
      err       <= err_n;
      err_code  <= code_n;
      if (fire_arg) arg_value <= fire_val;
    end
  end

`ifdef CMD_ECHO_EN
  // Echo rides the pop edge; a full TX FIFO simply drops the byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data <= '0;
      tx_push <= 1'b0;
    end else begin
      tx_push <= pop_n & ~tx_full;
      if (pop_n) tx_data <= rx_data;
    end
  end
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign tx_data        = '0;
  assign tx_push        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FWFT FIFO model, table of command strings feeding a scoreboard of
// expected strobes, plus hand-written reset, latency, timeout and mid-command reset sequences.
module tb_uart_cmd_parser;
  localparam int                NUM_CMD = 12;
  localparam int                TIMEOUT = 50;
  localparam logic [NUM_CMD-1:0] TOG    = 12'h0A1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, rx_empty, tx_full;
  logic [7:0]         rx_data;
  logic               rx_pop, arg_valid, err, tx_push;
  logic [NUM_CMD-1:0] cmd_pulse, cmd_level;
  logic [6:0]         arg_value;
  logic [1:0]         err_code;
  logic [7:0]         tx_data;
  logic               u4_rx_pop, u4_arg_valid, u4_err, u4_tx_push;
  logic [NUM_CMD-1:0] u4_cmd_pulse, u4_cmd_level;
  logic [3:0]         u4_arg_value;
  logic [1:0]         u4_err_code;
  logic [7:0]         u4_tx_data;

  uart_cmd_parser #(.TIMEOUT_CYC(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
    .cmd_pulse(cmd_pulse), .cmd_level(cmd_level), .arg_value(arg_value), .arg_valid(arg_valid),
    .err(err), .err_code(err_code), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full));

  // Narrow-argument instance on the same byte stream, for saturation.
  uart_cmd_parser #(.ARG_W(4), .TIMEOUT_CYC(TIMEOUT)) u_dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(u4_rx_pop),
    .cmd_pulse(u4_cmd_pulse), .cmd_level(u4_cmd_level), .arg_value(u4_arg_value),
    .arg_valid(u4_arg_valid), .err(u4_err), .err_code(u4_err_code), .tx_data(u4_tx_data),
    .tx_push(u4_tx_push), .tx_full(tx_full));

  typedef struct {
    bit         is_err;
    int         idx;
    bit         has_arg;
    int         value;
    int         value4;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    string s;
    bit    has_ev;
    ev_t   ev;
  } vec_t;

  logic [7:0]         fifo[$];
  ev_t                exp_q[$];
  vec_t               vecs[$];
  logic [NUM_CMD-1:0] level_m = '0;
  logic [1:0]         code_m  = '0;
  int                 n_vec = 0, n_err = 0, cyc = 0, last_pop_cyc = 0, last_ev_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    rx_empty = (fifo.size() == 0);
    rx_data  = rx_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
    drive_fifo();
  endtask

  function automatic ev_t mk_ev(input bit is_err, input int idx, input bit has_arg,
                                input int value, input int value4, input logic [1:0] code);
    ev_t e;
    e.is_err = is_err; e.idx = idx; e.has_arg = has_arg;
    e.value = value; e.value4 = value4; e.code = code;
    return e;
  endfunction

  task automatic add_vec(input string s, input bit has_ev, input ev_t e);
    vec_t v;
    v.s = s; v.has_ev = has_ev; v.ev = e;
    vecs.push_back(v);
  endtask

  // One clock: sample #1 after the edge, retire FIFO pops, score any strobe.
  task automatic step();
    ev_t                e;
    logic [NUM_CMD-1:0] exp_pulse;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_pop) begin
      check("pop_nonempty", 32'(fifo.size() != 0), 1);
      check("u4_pop", u4_rx_pop, 1);
`ifdef CMD_ECHO_EN
      check("echo_push", {u4_tx_push, tx_push}, {2{~tx_full}});
      if (tx_push && fifo.size() != 0) check("echo_data", {u4_tx_data, tx_data}, {fifo[0], fifo[0]});
`else
      check("echo_off", {u4_tx_push, u4_tx_data, tx_push, tx_data}, 0);
`endif
      if (fifo.size() != 0) void'(fifo.pop_front());
      last_pop_cyc = cyc;
      drive_fifo();
    end
`ifdef CMD_ECHO_EN
    if (tx_push && !rx_pop) check("echo_stray", tx_push, 0);
`endif
    if (|cmd_pulse || err || arg_valid) begin
      last_ev_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_event", {arg_valid, err, cmd_pulse}, 0);
      end else begin
        e = exp_q.pop_front();
        exp_pulse = '0;
        if (!e.is_err) exp_pulse[e.idx] = 1'b1;
        level_m = level_m ^ (exp_pulse & TOG);
        if (e.is_err) code_m = e.code;
        check("pulse", cmd_pulse, exp_pulse);
        check("err", {u4_err, err}, {2{e.is_err}});
        check("level", cmd_level, level_m);
        check("u4_pulse_level", {u4_cmd_pulse, u4_cmd_level}, {exp_pulse, level_m});
        check("arg_valid", {u4_arg_valid, arg_valid}, {2{e.has_arg}});
        if (e.is_err) check("err_code", {u4_err_code, err_code}, {e.code, e.code});
        if (e.has_arg) begin
          check("arg_value", arg_value, e.value);
          check("arg_value4", u4_arg_value, e.value4);
        end
      end
    end
  endtask

  // Run until the FIFO and scoreboard drain (bounded), then a few quiet cycles.
  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + fifo.size()), 0);
    exp_q.delete();
    fifo.delete();
    drive_fifo();
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ev_t none;
    none = mk_ev(0, 0, 0, 0, 0, 2'd0);
    add_vec("L",             1, mk_ev(0, 0,  0, 0,  0,  2'd0));
    add_vec("L",             1, mk_ev(0, 0,  0, 0,  0,  2'd0));
    add_vec("H23",           1, mk_ev(0, 1,  1, 23, 15, 2'd0));
    add_vec("M7\015",        1, mk_ev(0, 2,  1, 7,  7,  2'd0));
    add_vec("S99",           1, mk_ev(0, 3,  1, 99, 15, 2'd0));
    add_vec("H5\015\012",    1, mk_ev(0, 1,  1, 5,  5,  2'd0));
    add_vec("H23\015",       1, mk_ev(0, 1,  1, 23, 15, 2'd0));
    add_vec("H07",           1, mk_ev(0, 1,  1, 7,  7,  2'd0));
    add_vec("c",             1, mk_ev(0, 4,  0, 0,  0,  2'd0));
    add_vec("m",             1, mk_ev(0, 5,  0, 0,  0,  2'd0));
    add_vec("s",             1, mk_ev(0, 7,  0, 0,  0,  2'd0));
    add_vec("1",             1, mk_ev(0, 8,  0, 0,  0,  2'd0));
    add_vec("2",             1, mk_ev(0, 9,  0, 0,  0,  2'd0));
    add_vec("3",             1, mk_ev(0, 10, 0, 0,  0,  2'd0));
    add_vec("@",             1, mk_ev(0, 11, 0, 0,  0,  2'd0));
    add_vec("\015\012",      0, none);
    add_vec("Z",             1, mk_ev(1, 0,  0, 0,  0,  2'd0));
    add_vec("Mx",            1, mk_ev(1, 0,  0, 0,  0,  2'd1));
    add_vec("S\012",         1, mk_ev(1, 0,  0, 0,  0,  2'd2));
    add_vec("h",             1, mk_ev(1, 0,  0, 0,  0,  2'd0));
    add_vec("s",             1, mk_ev(0, 7,  0, 0,  0,  2'd0));

    // Reset held with a byte waiting: no pop, all outputs quiet.
    rst = 1'b0;
    tx_full = 1'b0;
    drive_fifo();
    repeat (3) step();
    push_str("L");
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_outs", {rx_pop, cmd_pulse, cmd_level, arg_valid, err}, 0);
      check("rst_vals", {arg_value, err_code, tx_push, tx_data}, 0);
    end
    rst = 1'b1;
    exp_q.push_back(mk_ev(0, 0, 0, 0, 0, 2'd0));
    wait_done("rst_release");

    // Single command latency: pulse 3 edges after rx_empty falls.
    push_str("r");
    exp_q.push_back(mk_ev(0, 6, 0, 0, 0, 2'd0));
    step(); check("lat_pop", rx_pop, 1);
    step(); check("lat_gap", {rx_pop, cmd_pulse}, 0);
    step(); check("lat_pulse", cmd_pulse, 12'h040);
    step(); check("lat_clear", cmd_pulse, 0);
    wait_done("latency");

    for (int i = 0; i < vecs.size(); i++) begin
      push_str(vecs[i].s);
      if (vecs[i].has_ev) exp_q.push_back(vecs[i].ev);
      wait_done($sformatf("vec%0d", i));
      check("level_idle", cmd_level, level_m);
      check("code_held", {u4_err_code, err_code}, {code_m, code_m});
    end

    // Argument timeout after TIMEOUT idle cycles in ARG_WAIT, then normal service.
    push_str("H5");
    exp_q.push_back(mk_ev(1, 0, 0, 0, 0, 2'd3));
    wait_done("timeout");
    check("timeout_cycles", last_ev_cyc - last_pop_cyc, 52);
    push_str("c");
    exp_q.push_back(mk_ev(0, 4, 0, 0, 0, 2'd0));
    wait_done("after_timeout");

    // TX FIFO full: parsing continues regardless.
    tx_full = 1'b1;
    push_str("c");
    exp_q.push_back(mk_ev(0, 4, 0, 0, 0, 2'd0));
    wait_done("tx_full");
    tx_full = 1'b0;

    // Reset mid-argument discards the partial 'H2'; a following '3' is a plain command.
    push_str("H2");
    repeat (6) step();
    rst = 1'b0;
    repeat (2) step();
    level_m = '0;
    code_m  = '0;
    check("rst_clear", {cmd_level, err_code, arg_value}, 0);
    rst = 1'b1;
    push_str("3");
    exp_q.push_back(mk_ev(0, 10, 0, 0, 0, 2'd0));
    wait_done("rst_partial");
    check("rst_arg_held", {u4_arg_value, arg_value}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
